// File: rtl/softmax_pkg.sv
// +----------------------------------------------------------------------+
// | softmax_pkg : shared Q8.8 number-format constants for softmax blocks |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

package softmax_pkg;
  localparam int                 FRAC_BITS = 8;
  localparam int                 Q88_W     = 16;
  localparam int                 DEFAULT_N = 8;
  localparam logic [Q88_W-1:0]   Q88_MIN   = 16'h8000;
endpackage

`default_nettype wire

// File: rtl/smax_cmp.sv
// +----------------------------------------------------------------------+
// | smax_cmp : combinational signed two-input maximum                    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module smax_cmp #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  // On a tie either operand is the same bit pattern, so the choice is irrelevant.
  assign y = ($signed(a) >= $signed(b)) ? a : b;

endmodule

`default_nettype wire

// File: rtl/softmax_vec_collector.sv
// +----------------------------------------------------------------------+
// | softmax_vec_collector : serial-to-parallel vector assembler with     |
// |                         running signed maximum, double buffered      |
// | Revision              : 1.0                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module softmax_vec_collector
  import softmax_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int W  = Q88_W,
  parameter int CW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           flush,
  input  logic           valid_in,
  input  logic [W-1:0]   in_x,
  output logic [N*W-1:0] x_flat,
  output logic [W-1:0]   max_x,
  output logic           valid_out,
  output logic [CW-1:0]  idx
);

  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  // Slot N-1 is never stored: the final element bypasses straight into x_flat.
  logic [W-1:0]         asm_buf [N-1];
  logic [(N-1)*W-1:0]   buf_flat;
  logic [W-1:0]         run_max;
  logic [W-1:0]         cmp_max;
  logic [W-1:0]         next_max;
  logic                 accept;
  logic                 is_last;

  assign accept  = en & valid_in & ~flush;
  assign is_last = (idx == LAST_IDX);

  smax_cmp #(.W(W)) u_cmp (
    .a (run_max),
    .b (in_x),
    .y (cmp_max)
  );

  // The first element of a vector seeds the running max regardless of its old value.
  assign next_max = (idx == '0) ? in_x : cmp_max;

  always_comb begin
    buf_flat = '0;
    for (int k = 0; k < N - 1; k++) begin
      buf_flat[k*W +: W] = asm_buf[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      run_max   <= '0;
      x_flat    <= '0;
      max_x     <= '0;
      valid_out <= 1'b0;
      for (int k = 0; k < N - 1; k++) begin
        asm_buf[k] <= '0;
      end
    end else if (en) begin
      valid_out <= accept & is_last;
      if (flush) begin
        idx <= '0;
      end else if (valid_in) begin
        run_max <= next_max;
        for (int k = 0; k < N - 1; k++) begin
          if (idx == CW'(k)) begin
            asm_buf[k] <= in_x;
          end
        end
        if (is_last) begin
          idx    <= '0;
          x_flat <= {in_x, buf_flat};
          max_x  <= next_max;
        end else begin
          idx <= idx + CW'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire
